tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
- REQ-001: Parameter TICK_DIV, default 100; clk cycles per measurement tick, giving 1 us ticks at 100 MHz; legal range 1..65535.
- REQ-002: Parameter STABLE_N, default 2; number of consecutive matching periods required before a note is accepted; legal range 1..7.
- REQ-003: Port clk, input, 1; system clock.
- REQ-004: Port rst_n, input, 1; one clock; reset is asynchronous and active-low.
- REQ-005: Port tone_in, input, 1; asynchronous square-wave tone, i.e. a bell/buzzer line.
- REQ-006: Port note, output, 4; decoded note: 0 = silence, 1..7 = do..si (C4..B4), 15 = unrecognised tone.
- REQ-007: Port period, output, 13; last measured full period in ticks.
- REQ-008: Port note_valid, output, 1; high while note holds an accepted value other than 0.
- REQ-009: Port note_strobe, output, 1; one-cycle pulse when note changes.

Function
- REQ-010: tone_in SHALL pass through a 2-flop synchroniser; a rising edge is detected as sync = 1 with the previous sync value = 0, giving 3 clk cycles of latency from the pin.
- REQ-011: A prescaler SHALL count 0..TICK_DIV-1 and issue a one-cycle tick at wrap; it is cleared on every detected edge so that each period is measured from the edge.
- REQ-012: A 13-bit period counter SHALL increment on each tick, saturate at 8191, and clear to 0 on each rising edge.
- REQ-013: The FSM states SHALL be IDLE, ARM and MEASURE; the reset state is IDLE.
- REQ-014: IDLE to ARM on the first rising edge; the counter is cleared.
- REQ-015: ARM to MEASURE on the next rising edge; the counter value is discarded, because the first interval after silence is unreliable.
- REQ-016: In MEASURE, each rising edge SHALL latch the counter into period, classify it, then clear the counter.
- REQ-017: From any state other than IDLE, if the counter reaches 8191, the FSM goes to IDLE, note becomes 0 and the stability count clears.
- REQ-018: The nominal periods in ticks SHALL be: 1 = 3817, 2 = 3401, 3 = 3030, 4 = 2865, 5 = 2551, 6 = 2273, 7 = 2024.
- REQ-019: Tolerance SHALL be nominal>>6, integer; a period matches note k when |period - nominal_k| <= tol_k (inclusive at both bounds); no period matches two notes.
- REQ-020: A period matching no entry SHALL classify as 15.
- REQ-021: Stability: if the classification equals the previous classification, the count increments (saturating at 7); otherwise the count is set to 1.
- REQ-022: When the count reaches STABLE_N and the classification differs from note, note SHALL update on the next clk.
- REQ-023: note_strobe SHALL be high for exactly that one cycle; the same strobe rule applies when a timeout forces note to 0 from a nonzero value.
- REQ-024: note_valid SHALL equal (note != 0), registered and aligned with note.
- REQ-025: An edge and a tick arriving in the same cycle: the edge takes priority; the counter clears and does not increment.
- REQ-026: An edge coinciding with saturation SHALL be treated as an edge; saturation is evaluated only when no edge is present.
- REQ-027: Arithmetic for the difference SHALL be 14-bit signed or compare-based, with no wrap errors at 0 or 8191.

Reset
- REQ-028: On rst_n low, asynchronously: note = 0, period = 0, note_valid = 0, note_strobe = 0, FSM = IDLE, counters = 0, stability count = 0, and synchroniser flops = 0.
- REQ-029: Reset asserted mid-measurement SHALL discard the partial period; after release, decoding restarts from IDLE and requires the ARM edge again.
- REQ-030: Deassertion needs no special handling beyond the synchroniser; an edge detected in the first cycle after release is valid.

Verification (TICK_DIV=1, STABLE_N=2 unless stated)
- REQ-031: Square wave with period 2273 clk, 6 edges -> note = 6 on the edge after the 2nd matching measured period, period = 2273, one note_strobe, note_valid = 1.
- REQ-032: Boundary: period 3030+47 = 3077 -> note = 3; period 3078 -> note = 15 after 2 periods.
- REQ-033: Tone stopped after note = 1 -> 8191 clk after the last edge, note = 0, note_valid = 0, one strobe, FSM = IDLE.
- REQ-034: Alternating periods 2551/2865 -> note unchanged and no strobe; a switch to steady 2865 -> note = 4 after 2 periods.
- REQ-035: rst_n pulsed low mid-period during a steady 3401 tone -> all outputs 0 immediately; note = 2 re-acquired after ARM plus 2 periods.
- REQ-036: TICK_DIV=100, 440 Hz tone at 100 MHz -> period = 2273 ±1, note = 6.

Source files
------------

// File: rtl/tone_decoder_if.sv
// tone_decoder_if: tone input pin and decoded-note outputs of the tone decoder.
//   tone_in     - asynchronous square-wave tone line
//   note        - decoded note (0 silence, 1..7 do..si, 15 unrecognised)
//   period      - last measured full period in ticks
//   note_valid  - note holds an accepted nonzero value
//   note_strobe - one-cycle pulse whenever note changes
interface tone_decoder_if;
    logic        tone_in;
    logic [3:0]  note;
    logic [12:0] period;
    logic        note_valid;
    logic        note_strobe;
    modport master (output tone_in, input note, period, note_valid, note_strobe);
    modport slave  (input tone_in, output note, period, note_valid, note_strobe);
endinterface

// File: rtl/tone_decoder.sv
// tone_decoder: measures the rising-edge period of a square-wave tone and maps it to a musical note.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of tone_decoder_if (tone_in in; note, period, note_valid, note_strobe out)
module tone_decoder #(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned STABLE_N = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [12:0] CNT_MAX = 13'h1fff;
    localparam logic [12:0] NOM [1:7] = '{13'd3817, 13'd3401, 13'd3030, 13'd2865, 13'd2551, 13'd2273, 13'd2024};
    state_t      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic [15:0] pre_q, pre_d;
    logic [12:0] cnt_q, cnt_d, period_q, period_d, meas;
    logic [3:0]  note_q, note_d, prev_q, prev_d, cls;
    logic [2:0]  stab_q, stab_d, stab_inc;
    logic        valid_q, strobe_q;
    logic        edge_det, tick;
    // Nominal bands never overlap and stay inside 1..8190, so plain unsigned compares cannot wrap.
    function automatic logic [3:0] classify(input logic [12:0] p);
        logic [3:0] c;
        c = 4'd15;
        for (int k = 1; k <= 7; k++)
            if (p >= NOM[k] - (NOM[k] >> 6) && p <= NOM[k] + (NOM[k] >> 6))
                c = 4'(k);
        return c;
    endfunction
    always_comb begin
        edge_det = s2_q & ~s3_q;
        tick     = pre_q == TICK_LAST;
        pre_d    = (edge_det || tick) ? '0 : pre_q + 16'd1;
        // The tick landing on the closing edge still belongs to the period that edge ends.
        meas     = (tick && cnt_q != CNT_MAX) ? cnt_q + 13'd1 : cnt_q;
        cnt_d    = edge_det ? '0 : meas;
        cls      = classify(meas);
        stab_inc = (cls != prev_q) ? 3'd1 : (stab_q == 3'd7) ? 3'd7 : stab_q + 3'd1;
        state_d  = state_q;
        period_d = period_q;
        prev_d   = prev_q;
        stab_d   = stab_q;
        note_d   = note_q;
        if (edge_det) begin
            state_d = (state_q == IDLE) ? ARM : MEASURE;
            if (state_q == MEASURE) begin
                period_d = meas;
                prev_d   = cls;
                stab_d   = stab_inc;
                if (32'(stab_inc) >= STABLE_N && cls != note_q)
                    note_d = cls;
            end
        end else if (state_q != IDLE && cnt_q == CNT_MAX) begin
            state_d = IDLE;
            note_d  = 4'd0;
            prev_d  = 4'd0;
            stab_d  = 3'd0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            pre_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            note_q   <= '0;
            prev_q   <= '0;
            stab_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= bus.tone_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            note_q   <= note_d;
            prev_q   <= prev_d;
            stab_q   <= stab_d;
            valid_q  <= note_d != 4'd0;
            strobe_q <= note_d != note_q;
        end
    end
    assign bus.note        = note_q;
    assign bus.period      = period_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_strobe = strobe_q;
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: scoreboard bench for tone_decoder; expected note/period pushed with each stimulus, popped on note_strobe.
module tb_tone_decoder;
    typedef struct packed {
        logic [3:0]  note;
        logic [12:0] period;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0, bad = 0, n_strobe = 0, cyc = 0, last_rise = 0, s0 = 0;
    bit   f_done = 1'b0;
    exp_t sb[$];
    tone_decoder_if bus ();
    tone_decoder_if bus2 ();
    tone_decoder #(.TICK_DIV(1), .STABLE_N(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    tone_decoder #(.TICK_DIV(3), .STABLE_N(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [3:0] n, input logic [12:0] p);
        sb.push_back('{note: n, period: p});
    endtask
    task automatic tone(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            bus.tone_in = 1'b1;
            last_rise   = cyc;
            wait_clk(p / 2);
            bus.tone_in = 1'b0;
            wait_clk(p - p / 2);
        end
    endtask
    task automatic rise();
        bus.tone_in = 1'b1;
        last_rise   = cyc;
        wait_clk(10);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_note"}, bus.note, 0);
        check({tag, "_period"}, bus.period, 0);
        check({tag, "_valid"}, bus.note_valid, 0);
        check({tag, "_strobe"}, bus.note_strobe, 0);
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.note_strobe) begin
            exp_t e;
            int   n;
            n = sb.size();
            n_strobe++;
            check("strobe_expected", 32'(n > 0), 1);
            if (n > 0) begin
                e = sb.pop_front();
                check("sb_note", bus.note, e.note);
                check("sb_period", bus.period, e.period);
                check("sb_valid", bus.note_valid, e.note != 4'd0);
            end
        end
    end
    initial begin
        @(posedge rst_n);
        wait_clk(10);
        for (int i = 0; i < 2; i++) begin
            bus2.tone_in = 1'b1;
            wait_clk(3409);
            bus2.tone_in = 1'b0;
            wait_clk(3410);
        end
        bus2.tone_in = 1'b1;
        wait_clk(20);
        check("f_note", bus2.note, 6);
        check("f_period", bus2.period, 2273);
        check("f_valid", bus2.note_valid, 1);
        f_done = 1'b1;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        rst_n        = 1'b0;
        bus.tone_in  = 1'b0;
        bus2.tone_in = 1'b0;
        wait_clk(3);
        check_zero("reset");
        rst_n = 1'b1;
        wait_clk(5);
        push(4'd6, 13'd2273);
        tone(2273, 5);
        check("a_note", bus.note, 6);
        check("a_period", bus.period, 2273);
        check("a_valid", bus.note_valid, 1);
        check("a_strobes", n_strobe, 1);
        push(4'd3, 13'd3077);
        tone(3077, 3);
        check("b_note3", bus.note, 3);
        push(4'd15, 13'd3078);
        tone(3078, 3);
        check("b_note15", bus.note, 15);
        s0 = n_strobe;
        for (int i = 0; i < 2; i++) begin
            tone(2551, 1);
            tone(2865, 1);
        end
        check("c_alt_strobes", n_strobe - s0, 0);
        check("c_alt_note", bus.note, 15);
        push(4'd4, 13'd2865);
        tone(2865, 2);
        check("c_note4", bus.note, 4);
        push(4'd1, 13'd3817);
        tone(3817, 2);
        rise();
        check("d_note1", bus.note, 1);
        push(4'd0, 13'd3817);
        wait_clk(last_rise + 8190 - cyc);
        check("d_pre_timeout", bus.note, 1);
        wait_clk(10);
        check("d_timeout_note", bus.note, 0);
        check("d_timeout_valid", bus.note_valid, 0);
        check("d_timeout_idle", 32'(dut.state_q), 0);
        bus.tone_in = 1'b0;
        wait_clk(20);
        push(4'd2, 13'd3401);
        tone(3401, 3);
        rise();
        check("e_note2", bus.note, 2);
        wait_clk(1000);
        rst_n = 1'b0;
        #1;
        check_zero("e_rst");
        check("e_rst_idle", 32'(dut.state_q), 0);
        wait_clk(2);
        bus.tone_in = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(1000);
        check("e_after_rst_note", bus.note, 0);
        push(4'd2, 13'd3401);
        tone(3401, 3);
        rise();
        check("e_reacq_note", bus.note, 2);
        check("e_reacq_period", bus.period, 3401);
        for (int i = 0; i < 30000 && !f_done; i++) wait_clk(1);
        check("f_done", f_done, 1);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
